load_store_unit: RTL and testbench
==================================

# load_store_unit

Consumer end of the address-unit output interface: accepts computed memory operations (address, load/store flag, size code, instruction tag), buffers them in a small in-order queue, and executes each against the byte-wide data RAM port. Loads are reassembled and size/sign-adjusted, then broadcast with their instruction tag; stores emit a completion broadcast. Sits between the address unit and the data RAM, feeding the result broadcast bus.

## Interface
- DEPTH, 4, queue entries (power of two, ≥2)
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operation presented this cycle
- in_ready  out  1  queue can accept; transfer on in_valid && in_ready at rising edge
- addr_input  in  32  effective byte address
- is_load_input  in  1  1 = load, 0 = store
- reg_number_input  in  3  size code: 000 byte, 001 half, 010 word, 100 byte-unsigned, 101 half-unsigned
- instruction_number_input  in  4  instruction tag
- store_data_input  in  32  store data (ignored for loads)
- mem_a  out  32  RAM byte address
- mem_wr  out  1  1 = write mem_dout to mem_a this cycle
- mem_dout  out  8  RAM write byte
- mem_din  in  8  RAM read byte, valid the cycle after mem_a presented with mem_wr=0
- out_valid  out  1  one-cycle completion pulse
- out_value  out  32  load result; 0 for stores
- out_instruction_number  out  4  tag of completed operation
- out_is_load  out  1  1 = completed op was a load

## Operation
- Queue: FIFO of DEPTH entries {addr, is_load, size, tag, data}; in_ready = (count < DEPTH), no bypass when full even if popping same cycle.
- Byte count N: codes 000/100 → 1, 001/101 → 2, 010 → 4; codes 011/110/111 treated as word (N=4, no extension).
- FSM states: IDLE, ACCESS, LAST, DONE.
- IDLE: if queue non-empty, pop head into op registers, byte index k=0, → ACCESS.
- ACCESS: drive mem_a = addr + k (mod 2^32), mem_wr = !is_load, mem_dout = data[8k+7:8k]; for loads capture mem_din into byte k−1 when k≥1. k increments; after k=N−1 → LAST (load) or DONE (store).
- LAST: capture mem_din into byte N−1; mem_wr=0; → DONE.
- DONE: out_valid=1 with tag, is_load and value; loads zero-extend (100/101) or sign-extend (000/001) to 32 bits. If queue non-empty, pop and → ACCESS directly; else → IDLE.
- No alignment check; misaligned accesses proceed byte-sequentially, address wraps at 2^32.
- Outside ACCESS: mem_wr=0, mem_a=0, mem_dout=0.

## Timing
- Cycle c = interval after rising edge c. Op accepted at edge 0 into empty queue with FSM IDLE: popped at edge 1, ACCESS cycles 1..N.
- Load: out_valid in cycle N+2 (LB: 3, LH: 4, LW: 6). Store: out_valid in cycle N+1 (SB: 2, SW: 5).
- Back-to-back: next queued op's first ACCESS is the cycle after DONE; LW throughput one op per 6 cycles.
- out_valid is exactly one cycle; out_value/tag hold last value otherwise (don't-care when out_valid=0).
- Simultaneous push and pop: both take effect; count unchanged.
- Reset values: state IDLE, queue empty, in_ready=1, out_valid=0, out_value=0, out_instruction_number=0, out_is_load=0, mem_a=0, mem_wr=0, mem_dout=0.
- Reset mid-operation: in-flight and queued ops discarded, no out_valid; a store may have partially written bytes — accepted behaviour, upstream flushes on reset.

## Structure
- Package viola_mem_pkg: size-code constants, FSM state enum, byte-count function, sign/zero-extend function, default DEPTH.
- Sub-module lsu_fifo: parameterised DEPTH-entry FIFO (push/pop/count/full/empty, synchronous reset), reused for other in-order queues.

## Test plan
- LW addr 0x100, RAM bytes 0x78,0x56,0x34,0x12 at 0x100..0x103, tag 5 accepted edge 0 -> mem_a 0x100..0x103 cycles 1–4, out_valid cycle 6, out_value 0x12345678, tag 5.
- LB vs LBU at byte 0x80 -> out_value 0xFFFFFF80 and 0x00000080; LH at 0x8001 halfword -> 0xFFFF8001.
- SH data 0xAABBCCDD addr 0x200 tag 3 -> mem_wr=1 cycles 1–2, bytes 0xDD@0x200, 0xCC@0x201, out_valid cycle 3, out_value 0, out_is_load 0.
- Push 5 ops with FSM busy, DEPTH=4 -> in_ready low after 4th; 5th held until first pop; completions in push order with correct tags.
- LW addr 0xFFFFFFFE -> mem_a 0xFFFFFFFE,0xFFFFFFFF,0x0,0x1.
- Assert rst during ACCESS of a queued SW with 2 ops pending -> next cycle all outputs at reset values, no out_valid afterwards, in_ready=1.

Source files
------------

// File: rtl/viola_mem_pkg.sv
// viola_mem_pkg: shared definitions for the load/store path.
//   - size-code constants for the address-unit operation encoding
//   - FSM state enum for load_store_unit
//   - queued operation record (lsu_op_t)
//   - byte_count(): bytes touched by a size code
//   - size_extend(): sign/zero extension of an assembled load value
package viola_mem_pkg;

  localparam logic [2:0] SZ_B  = 3'b000;
  localparam logic [2:0] SZ_H  = 3'b001;
  localparam logic [2:0] SZ_W  = 3'b010;
  localparam logic [2:0] SZ_BU = 3'b100;
  localparam logic [2:0] SZ_HU = 3'b101;

  localparam int LSU_DEPTH_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_LAST   = 2'd2,
    ST_DONE   = 2'd3
  } lsu_state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic        is_load;
    logic [2:0]  size;
    logic [3:0]  tag;
    logic [31:0] data;
  } lsu_op_t;

  // Unused codes (011/110/111) fall through to a plain word access.
  function automatic logic [2:0] byte_count(input logic [2:0] size);
    case (size)
      SZ_B, SZ_BU: byte_count = 3'd1;
      SZ_H, SZ_HU: byte_count = 3'd2;
      default:     byte_count = 3'd4;
    endcase
  endfunction

  function automatic logic [31:0] size_extend(input logic [2:0] size,
                                              input logic [31:0] raw);
    case (size)
      SZ_B:    size_extend = {{24{raw[7]}}, raw[7:0]};
      SZ_H:    size_extend = {{16{raw[15]}}, raw[15:0]};
      SZ_BU:   size_extend = {24'd0, raw[7:0]};
      SZ_HU:   size_extend = {16'd0, raw[15:0]};
      default: size_extend = raw;
    endcase
  endfunction

endpackage

// File: rtl/lsu_fifo.sv
// lsu_fifo: generic DEPTH-entry in-order queue with synchronous reset.
//   clk, rst          clock / synchronous active-high reset
//   i_push, i_data    write request (ignored when full)
//   i_pop             read request (ignored when empty); o_data is the head
//   o_count, o_empty  occupancy status
// Push and pop in the same cycle both take effect.
module lsu_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign w_push  = i_push && (r_count != FULL_CNT);
  assign w_pop   = i_pop && (r_count != '0);
  assign o_data  = r_mem[r_rptr];
  assign o_count = r_count;
  assign o_empty = (r_count == '0);

  // Storage has no reset; only pointers/count define validity.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_data;
  end

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: queues address-unit memory operations and runs each one
// byte-sequentially against a byte-wide RAM port, broadcasting completions.
//   clk, rst                       clock / synchronous active-high reset
//   in_valid, in_ready             operation handshake
//   addr_input, is_load_input,     operation fields (reg_number_input is the
//   reg_number_input,              size code, store_data_input only used by
//   instruction_number_input,      stores)
//   store_data_input
//   mem_a, mem_wr, mem_dout        RAM request (one byte per cycle)
//   mem_din                        RAM read byte, one cycle after mem_a
//   out_valid, out_value,          one-cycle completion broadcast
//   out_instruction_number, out_is_load
module load_store_unit
  import viola_mem_pkg::*;
#(
  parameter int DEPTH = LSU_DEPTH_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] addr_input,
  input  logic        is_load_input,
  input  logic [2:0]  reg_number_input,
  input  logic [3:0]  instruction_number_input,
  input  logic [31:0] store_data_input,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  output logic [7:0]  mem_dout,
  input  logic [7:0]  mem_din,
  output logic        out_valid,
  output logic [31:0] out_value,
  output logic [3:0]  out_instruction_number,
  output logic        out_is_load
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_CNT = DEPTH[CW-1:0];

  lsu_state_t  r_state;
  logic [31:0] r_addr;
  logic        r_is_load;
  logic [2:0]  r_size;
  logic [3:0]  r_tag;
  logic [31:0] r_data;     // store data, overwritten byte-wise by load data
  logic [1:0]  r_k;        // byte index of the current access
  logic [31:0] r_out_value;
  logic [3:0]  r_out_tag;
  logic        r_out_is_load;

  lsu_op_t        w_in_op;
  lsu_op_t        w_head;
  logic [CW-1:0]  w_count;
  logic           w_empty;
  logic           w_pop;
  logic [2:0]     w_nbytes;
  logic           w_k_last;
  logic [31:0]    w_assembled;
  logic           w_access;

  assign w_in_op = '{addr:    addr_input,
                     is_load: is_load_input,
                     size:    reg_number_input,
                     tag:     instruction_number_input,
                     data:    store_data_input};

  lsu_fifo #(
    .WIDTH ($bits(lsu_op_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (in_valid),
    .i_data  (w_in_op),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_count (w_count),
    .o_empty (w_empty)
  );

  // No bypass: a full queue refuses even when the head is leaving.
  assign in_ready = (w_count < DEPTH_CNT);

  // The next op is taken from IDLE or straight out of DONE.
  assign w_pop = ((r_state == ST_IDLE) || (r_state == ST_DONE)) && !w_empty;

  assign w_nbytes = byte_count(r_size);
  assign w_k_last = ({1'b0, r_k} == (w_nbytes - 3'd1));
  assign w_access = (r_state == ST_ACCESS);

  // Final load byte arrives during LAST; merge it before extension.
  always_comb begin
    w_assembled = r_data;
    w_assembled[{r_k, 3'b000} +: 8] = mem_din;
  end

  assign mem_a    = w_access ? (r_addr + {30'd0, r_k}) : 32'd0;
  assign mem_wr   = w_access && !r_is_load;
  assign mem_dout = w_access ? r_data[{r_k, 3'b000} +: 8] : 8'd0;

  assign out_valid              = (r_state == ST_DONE);
  assign out_value              = r_out_value;
  assign out_instruction_number = r_out_tag;
  assign out_is_load            = r_out_is_load;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_addr        <= '0;
      r_is_load     <= 1'b0;
      r_size        <= '0;
      r_tag         <= '0;
      r_data        <= '0;
      r_k           <= '0;
      r_out_value   <= '0;
      r_out_tag     <= '0;
      r_out_is_load <= 1'b0;
    end else begin
      if (w_pop) begin
        r_addr    <= w_head.addr;
        r_is_load <= w_head.is_load;
        r_size    <= w_head.size;
        r_tag     <= w_head.tag;
        r_data    <= w_head.data;
        r_k       <= '0;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_pop) r_state <= ST_ACCESS;
        end
        ST_ACCESS: begin
          // mem_din now holds the byte requested in the previous cycle.
          if (r_is_load && (r_k != 2'd0))
            r_data[{r_k - 2'd1, 3'b000} +: 8] <= mem_din;
          if (w_k_last) begin
            if (r_is_load) begin
              r_state <= ST_LAST;
            end else begin
              r_state       <= ST_DONE;
              r_out_value   <= '0;
              r_out_tag     <= r_tag;
              r_out_is_load <= 1'b0;
            end
          end else begin
            r_k <= r_k + 2'd1;
          end
        end
        ST_LAST: begin
          r_data        <= w_assembled;
          r_out_value   <= size_extend(r_size, w_assembled);
          r_out_tag     <= r_tag;
          r_out_is_load <= 1'b1;
          r_state       <= ST_DONE;
        end
        ST_DONE: begin
          r_state <= w_pop ? ST_ACCESS : ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;
  import viola_mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] addr_input;
  logic        is_load_input;
  logic [2:0]  reg_number_input;
  logic [3:0]  instruction_number_input;
  logic [31:0] store_data_input;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic [7:0]  mem_dout;
  logic [7:0]  mem_din;
  logic        out_valid;
  logic [31:0] out_value;
  logic [3:0]  out_instruction_number;
  logic        out_is_load;

  int vecs = 0;
  int errs = 0;

  // RAM model: registered read, write from DUT or from bench preload.
  logic [7:0]  ram [65536];
  logic        tb_we = 1'b0;
  logic [15:0] tb_wa = '0;
  logic [7:0]  tb_wd = '0;

  logic [3:0]  comp_tags [$];
  logic [31:0] comp_vals [$];

  load_store_unit #(.DEPTH(4)) dut (
    .clk                      (clk),
    .rst                      (rst),
    .in_valid                 (in_valid),
    .in_ready                 (in_ready),
    .addr_input               (addr_input),
    .is_load_input            (is_load_input),
    .reg_number_input         (reg_number_input),
    .instruction_number_input (instruction_number_input),
    .store_data_input         (store_data_input),
    .mem_a                    (mem_a),
    .mem_wr                   (mem_wr),
    .mem_dout                 (mem_dout),
    .mem_din                  (mem_din),
    .out_valid                (out_valid),
    .out_value                (out_value),
    .out_instruction_number   (out_instruction_number),
    .out_is_load              (out_is_load)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (tb_we)       ram[tb_wa] <= tb_wd;
    else if (mem_wr) ram[mem_a[15:0]] <= mem_dout;
    mem_din <= ram[mem_a[15:0]];
  end

  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      comp_tags.push_back(out_instruction_number);
      comp_vals.push_back(out_value);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [15:0] a, input logic [7:0] d);
    tb_we = 1'b1; tb_wa = a; tb_wd = d;
    tick();
    tb_we = 1'b0;
  endtask

  task automatic set_op(input logic [31:0] a, input logic ld, input logic [2:0] sz,
                        input logic [3:0] tg, input logic [31:0] d);
    addr_input = a; is_load_input = ld; reg_number_input = sz;
    instruction_number_input = tg; store_data_input = d;
  endtask

  // Push one op into an idle unit and wait for its completion.
  task automatic run_op(input logic [31:0] a, input logic ld, input logic [2:0] sz,
                        input logic [3:0] tg, input logic [31:0] d,
                        output int lat, output logic [31:0] v,
                        output logic [3:0] t, output logic l);
    set_op(a, ld, sz, tg, d);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 30) begin
      tick();
      lat++;
    end
    v = out_value; t = out_instruction_number; l = out_is_load;
    tick();
  endtask

  initial begin
    int          lat;
    logic [31:0] v;
    logic [3:0]  t;
    logic        l;
    int          base;
    int          stall;
    int          wr_seen;
    int          guard;
    logic [3:0]  exp_tags [6];
    logic [31:0] exp_vals [6];

    rst = 1'b1; in_valid = 1'b0;
    set_op(32'd0, 1'b0, 3'd0, 4'd0, 32'd0);
    preload(16'h0100, 8'h78); preload(16'h0101, 8'h56);
    preload(16'h0102, 8'h34); preload(16'h0103, 8'h12);
    preload(16'h0300, 8'h80);
    preload(16'h8001, 8'h01); preload(16'h8002, 8'h80);
    preload(16'hFFFE, 8'h11); preload(16'hFFFF, 8'h22);
    preload(16'h0000, 8'h33); preload(16'h0001, 8'h44);
    tick();
    rst = 1'b0;
    tick();

    // Reset state
    chk("rst_in_ready",  32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_value", out_value, 32'd0);
    chk("rst_out_tag",   32'(out_instruction_number), 32'd0);
    chk("rst_out_isld",  32'(out_is_load), 32'd0);
    chk("rst_mem_a",     mem_a, 32'd0);
    chk("rst_mem_wr",    32'(mem_wr), 32'd0);
    chk("rst_mem_dout",  32'(mem_dout), 32'd0);

    // LW 0x100 tag 5, cycle-by-cycle
    set_op(32'h100, 1'b1, SZ_W, 4'd5, 32'd0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      tick();
      chk($sformatf("lw_mem_a_c%0d", c), mem_a, 32'h100 + 32'(c - 1));
      chk($sformatf("lw_mem_wr_c%0d", c), 32'(mem_wr), 32'd0);
    end
    tick();
    chk("lw_c5_no_valid", 32'(out_valid), 32'd0);
    tick();
    chk("lw_c6_valid", 32'(out_valid), 32'd1);
    chk("lw_value",    out_value, 32'h12345678);
    chk("lw_tag",      32'(out_instruction_number), 32'd5);
    chk("lw_isload",   32'(out_is_load), 32'd1);
    tick();
    chk("lw_c7_pulse_end", 32'(out_valid), 32'd0);

    // LB / LBU / LH sign and zero extension
    run_op(32'h300, 1'b1, SZ_B, 4'd1, 32'd0, lat, v, t, l);
    chk("lb_lat", 32'(lat), 32'd3);
    chk("lb_val", v, 32'hFFFFFF80);
    run_op(32'h300, 1'b1, SZ_BU, 4'd2, 32'hFFFFFFFF, lat, v, t, l);
    chk("lbu_lat", 32'(lat), 32'd3);
    chk("lbu_val", v, 32'h00000080);
    run_op(32'h8001, 1'b1, SZ_H, 4'd3, 32'd0, lat, v, t, l);
    chk("lh_lat", 32'(lat), 32'd4);
    chk("lh_val", v, 32'hFFFF8001);

    // SH 0xAABBCCDD @0x200 tag 3
    set_op(32'h200, 1'b0, SZ_H, 4'd3, 32'hAABBCCDD);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    chk("sh_c1_wr",   32'(mem_wr), 32'd1);
    chk("sh_c1_a",    mem_a, 32'h200);
    chk("sh_c1_dout", 32'(mem_dout), 32'hDD);
    tick();
    chk("sh_c2_wr",   32'(mem_wr), 32'd1);
    chk("sh_c2_a",    mem_a, 32'h201);
    chk("sh_c2_dout", 32'(mem_dout), 32'hCC);
    tick();
    chk("sh_c3_valid", 32'(out_valid), 32'd1);
    chk("sh_c3_wr",    32'(mem_wr), 32'd0);
    chk("sh_value",    out_value, 32'd0);
    chk("sh_isload",   32'(out_is_load), 32'd0);
    chk("sh_tag",      32'(out_instruction_number), 32'd3);
    tick();
    chk("sh_ram_202_untouched", 32'(ram[16'h0202] === 8'hBB), 32'd0);
    run_op(32'h200, 1'b1, SZ_HU, 4'd4, 32'd0, lat, v, t, l);
    chk("lhu_val", v, 32'h0000CCDD);
    chk("lhu_tag", 32'(t), 32'd4);

    // Wraparound LW at 0xFFFFFFFE
    set_op(32'hFFFFFFFE, 1'b1, SZ_W, 4'd9, 32'd0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); chk("wrap_a0", mem_a, 32'hFFFFFFFE);
    tick(); chk("wrap_a1", mem_a, 32'hFFFFFFFF);
    tick(); chk("wrap_a2", mem_a, 32'h00000000);
    tick(); chk("wrap_a3", mem_a, 32'h00000001);
    tick(); tick();
    chk("wrap_valid", 32'(out_valid), 32'd1);
    chk("wrap_val",   out_value, 32'h44332211);
    tick();

    // Queue fill: one op in flight, then five more pushed
    base = comp_tags.size();
    exp_tags = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6};
    exp_vals = '{32'h12345678, 32'd0, 32'h80, 32'd0, 32'hFFFF8001, 32'hCAFEF00D};
    set_op(32'h100, 1'b1, SZ_W, 4'd1, 32'd0);
    in_valid = 1'b1;
    tick();
    set_op(32'h400, 1'b0, SZ_B, 4'd2, 32'h11);
    chk("q_ready_c0", 32'(in_ready), 32'd1);
    tick();
    set_op(32'h300, 1'b1, SZ_BU, 4'd3, 32'd0);
    tick();
    set_op(32'h404, 1'b0, SZ_W, 4'd4, 32'hCAFEF00D);
    chk("q_ready_c2", 32'(in_ready), 32'd1);
    tick();
    set_op(32'h8001, 1'b1, SZ_H, 4'd5, 32'd0);
    tick();
    set_op(32'h404, 1'b1, SZ_W, 4'd6, 32'd0);
    chk("q_ready_low_full", 32'(in_ready), 32'd0);
    stall = 0;
    while (in_ready !== 1'b1 && stall < 20) begin
      tick();
      stall++;
    end
    chk("q_stall_cycles", 32'(stall), 32'd3);
    tick();
    in_valid = 1'b0;
    guard = 0;
    while (comp_tags.size() < base + 6 && guard < 200) begin
      tick();
      guard++;
    end
    chk("q_completions", 32'(comp_tags.size() - base), 32'd6);
    for (int i = 0; i < 6; i++) begin
      if (base + i < comp_tags.size()) begin
        chk($sformatf("q_tag%0d", i), 32'(comp_tags[base + i]), 32'(exp_tags[i]));
        chk($sformatf("q_val%0d", i), comp_vals[base + i], exp_vals[i]);
      end
    end
    tick(); tick();

    // Reset during a store's ACCESS with two ops queued behind it
    set_op(32'h500, 1'b0, SZ_W, 4'd7, 32'h01020304);
    in_valid = 1'b1;
    tick();
    set_op(32'h100, 1'b1, SZ_W, 4'd8, 32'd0);
    tick();
    set_op(32'h600, 1'b0, SZ_B, 4'd10, 32'h55);
    tick();
    in_valid = 1'b0;
    chk("rsto_in_access", 32'(mem_wr), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rsto_out_valid", 32'(out_valid), 32'd0);
    chk("rsto_out_value", out_value, 32'd0);
    chk("rsto_out_tag",   32'(out_instruction_number), 32'd0);
    chk("rsto_out_isld",  32'(out_is_load), 32'd0);
    chk("rsto_mem_a",     mem_a, 32'd0);
    chk("rsto_mem_wr",    32'(mem_wr), 32'd0);
    chk("rsto_mem_dout",  32'(mem_dout), 32'd0);
    chk("rsto_in_ready",  32'(in_ready), 32'd1);
    base = comp_tags.size();
    wr_seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (mem_wr === 1'b1 || mem_a !== 32'd0) wr_seen++;
    end
    chk("rsto_no_completion", 32'(comp_tags.size() - base), 32'd0);
    chk("rsto_mem_quiet",     32'(wr_seen), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
